mux2a1_cuatrobits_tx: RTL and testbench

Transmit-side 2:1 lane merger. It takes two 4-bit lanes, each with a valid/ready handshake, and interleaves them onto one 4-bit stream with valid/ready, lane 0 first. It is the counterpart of the receive-side 1:2 demux, which splits the stream back into lane 0 and lane 1 by alternating position. Each lane is buffered in a small FIFO so that upstream producers and downstream backpressure are decoupled.

---
 rtl/mux2a1_cuatrobits_tx_pkg.sv | 19 +
 rtl/mux2a1_cuatrobits_tx_fifo_lane_sync.sv | 68 ++++++
 rtl/mux2a1_cuatrobits_tx.sv | 128 ++++++++++++
 tb/tb_mux2a1_cuatrobits_tx.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux2a1_cuatrobits_tx_pkg.sv
// Shared definitions for the 2:1 transmit lane merger.
// Optional feature macro used by the top: MUX2A1_SKIP_EMPTY_EN.
package mux2a1_cuatrobits_tx_pkg;

  localparam int DATA_W_DEF     = 4;
  localparam int FIFO_DEPTH_DEF = 2;

  // Lane identifiers as they appear on lane_out and in the selector.
  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  typedef logic [DATA_W_DEF-1:0] lane_word_t;

  // Width needed to hold an occupancy count of 0..depth inclusive.
  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mux2a1_cuatrobits_tx_fifo_lane_sync.sv
// Single-clock lane FIFO: push/pop, head-of-queue view, occupancy count.
// Pointers wrap naturally because the depth is a power of two.
module fifo_lane_sync
  import mux2a1_cuatrobits_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF
)
(
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_push,
  input  logic [DATA_W-1:0]         i_push_data,
  input  logic                      i_pop,
  output logic [DATA_W-1:0]         o_head,
  output logic [count_w(DEPTH)-1:0] o_count,
  output logic                      o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = count_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == DEPTH_C);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mux2a1_cuatrobits_tx.sv
// Transmit-side 2:1 lane merger: two buffered 4-bit lanes interleaved onto one
// registered stream, lane 0 first.
// Handshake: a word moves across an interface on a rising edge where valid and
// ready are both 1; a registered valid_out stays asserted with stable data and
// lane_out until ready_out is seen high.
// Optional feature macro: MUX2A1_SKIP_EMPTY_EN (serve the other lane when the
// selected one is empty); without it the output strictly alternates lanes.
module mux2a1_cuatrobits_tx
  import mux2a1_cuatrobits_tx_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
)
(
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in0,
  input  logic              valid_in0,
  output logic              ready_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic              valid_in1,
  output logic              ready_in1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              lane_out,
  input  logic              ready_out
);

  localparam int CW = count_w(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [DATA_W-1:0] w_head0;
  logic [DATA_W-1:0] w_head1;
  logic [CW-1:0]     w_count0;
  logic [CW-1:0]     w_count1;
  logic              w_empty0;
  logic              w_empty1;
  logic              w_push0;
  logic              w_push1;
  logic              w_pop0;
  logic              w_pop1;
  logic              w_out_free;
  logic              w_sel_avail;
  logic              w_serve_lane;
  logic              w_load;
  logic [DATA_W-1:0] w_serve_word;

  logic [DATA_W-1:0] r_data_out;
  logic              r_valid_out;
  logic              r_lane_out;
  logic              r_selector;

  // Acceptance depends on the registered count only, so a pop in the same
  // cycle does not open a slot early.
  assign ready_in0 = !reset && (w_count0 < DEPTH_C);
  assign ready_in1 = !reset && (w_count1 < DEPTH_C);
  assign w_push0   = valid_in0 && ready_in0;
  assign w_push1   = valid_in1 && ready_in1;

  fifo_lane_sync #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo0 (
    .i_clk       (clk_4f),
    .i_reset     (reset),
    .i_push      (w_push0),
    .i_push_data (data_in0),
    .i_pop       (w_pop0),
    .o_head      (w_head0),
    .o_count     (w_count0),
    .o_empty     (w_empty0)
  );

  fifo_lane_sync #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo1 (
    .i_clk       (clk_4f),
    .i_reset     (reset),
    .i_push      (w_push1),
    .i_push_data (data_in1),
    .i_pop       (w_pop1),
    .o_head      (w_head1),
    .o_count     (w_count1),
    .o_empty     (w_empty1)
  );

  // Pick the lane to serve and decide whether the output register loads.
  always_comb begin
    w_out_free   = !r_valid_out || ready_out;
    w_sel_avail  = (r_selector == LANE0) ? !w_empty0 : !w_empty1;
    w_serve_lane = r_selector;
    w_load       = 1'b0;
`ifdef MUX2A1_SKIP_EMPTY_EN
    if (!w_sel_avail) begin
      w_serve_lane = !r_selector;
    end
    w_load = w_out_free && (!w_empty0 || !w_empty1);
`else
    w_load = w_out_free && w_sel_avail;
`endif
    w_serve_word = (w_serve_lane == LANE0) ? w_head0 : w_head1;
    w_pop0       = w_load && (w_serve_lane == LANE0);
    w_pop1       = w_load && (w_serve_lane != LANE0);
  end

  // Output register and lane selector; a stall freezes both.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_lane_out  <= LANE0;
      r_selector  <= LANE0;
    end else if (w_load) begin
      r_data_out  <= w_serve_word;
      r_valid_out <= 1'b1;
      r_lane_out  <= w_serve_lane;
      r_selector  <= !w_serve_lane;
    end else if (w_out_free) begin
      r_valid_out <= 1'b0;
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign lane_out  = r_lane_out;

endmodule

// File: tb/tb_mux2a1_cuatrobits_tx.sv
// Self-checking bench for mux2a1_cuatrobits_tx, default or MUX2A1_SKIP_EMPTY_EN build.
module tb_mux2a1_cuatrobits_tx;
  import mux2a1_cuatrobits_tx_pkg::*;

  localparam int DEPTH = 2;

  // ---------------- clock / reset / DUT ----------------
  logic       clk_4f = 1'b0;
  logic       reset = 1'b1;
  lane_word_t data_in0 = '0;
  logic       valid_in0 = 1'b0;
  logic       ready_in0;
  lane_word_t data_in1 = '0;
  logic       valid_in1 = 1'b0;
  logic       ready_in1;
  lane_word_t data_out;
  logic       valid_out;
  logic       lane_out;
  logic       ready_out = 1'b0;

  always #5 clk_4f = ~clk_4f;

  mux2a1_cuatrobits_tx #(.DATA_W(4), .FIFO_DEPTH(DEPTH)) dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .data_in0  (data_in0),
    .valid_in0 (valid_in0),
    .ready_in0 (ready_in0),
    .data_in1  (data_in1),
    .valid_in1 (valid_in1),
    .ready_in1 (ready_in1),
    .data_out  (data_out),
    .valid_out (valid_out),
    .lane_out  (lane_out),
    .ready_out (ready_out)
  );

  // ---------------- reference model state ----------------
  lane_word_t m_q0[$];
  lane_word_t m_q1[$];
  logic       m_sel  = 1'b0;
  logic       m_vout = 1'b0;
  lane_word_t m_dout = '0;
  logic       m_lout = 1'b0;

  // ---------------- scoreboard ----------------
  logic [4:0] exp_q[$];
  logic [4:0] obs_q[$];
  int         obs_cyc[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic       mon_en = 1'b0;

  // One clock: record the handshake seen this cycle, step the model across
  // the edge using the inputs presented, then settle 1 time unit past it.
  task automatic tick();
    logic p0, p1, free, a0, a1, lane, load;
    lane_word_t w;
    if (valid_out === 1'b1 && ready_out === 1'b1) begin
      obs_q.push_back({lane_out, data_out});
      obs_cyc.push_back(cyc);
    end
    p0 = !reset && valid_in0 && (m_q0.size() < DEPTH);
    p1 = !reset && valid_in1 && (m_q1.size() < DEPTH);
    @(posedge clk_4f);
    if (reset) begin
      m_q0.delete();
      m_q1.delete();
      m_sel  = 1'b0;
      m_vout = 1'b0;
      m_dout = '0;
      m_lout = 1'b0;
    end else begin
      free = !m_vout || ready_out;
      a0   = (m_q0.size() != 0);
      a1   = (m_q1.size() != 0);
      lane = m_sel;
      load = free && (m_sel ? a1 : a0);
`ifdef MUX2A1_SKIP_EMPTY_EN
      if (free && !load && (a0 || a1)) begin
        lane = !m_sel;
        load = 1'b1;
      end
`endif
      if (load) begin
        w      = lane ? m_q1.pop_front() : m_q0.pop_front();
        m_dout = w;
        m_lout = lane;
        m_vout = 1'b1;
        m_sel  = !lane;
      end else if (free) begin
        m_vout = 1'b0;
      end
      if (p0) m_q0.push_back(data_in0);
      if (p1) m_q1.push_back(data_in1);
    end
    #1;
    cyc++;
  endtask

  task automatic drive(input logic v0, input lane_word_t d0,
                       input logic v1, input lane_word_t d1);
    valid_in0 = v0;
    data_in0  = d0;
    valid_in1 = v1;
    data_in1  = d1;
    tick();
  endtask

  task automatic idle(input int n);
    valid_in0 = 1'b0;
    valid_in1 = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    valid_in0 = 1'b0;
    valid_in1 = 1'b0;
    for (int i = 0; i < n; i++) tick();
    reset = 1'b0;
    #1;
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  // Continuous comparison of DUT against the model, mid-cycle.
  always @(negedge clk_4f) begin
    if (mon_en) begin
      n_checks++;
      if (ready_in0 !== (!reset && (m_q0.size() < DEPTH))) begin
        n_errors++;
        $display("FAIL mon_ready_in0 cyc=%0d got %b want %b", cyc, ready_in0, (!reset && (m_q0.size() < DEPTH)));
      end
      n_checks++;
      if (ready_in1 !== (!reset && (m_q1.size() < DEPTH))) begin
        n_errors++;
        $display("FAIL mon_ready_in1 cyc=%0d got %b want %b", cyc, ready_in1, (!reset && (m_q1.size() < DEPTH)));
      end
      n_checks++;
      if (valid_out !== m_vout) begin
        n_errors++;
        $display("FAIL mon_valid_out cyc=%0d got %b want %b", cyc, valid_out, m_vout);
      end
      if (m_vout) begin
        n_checks++;
        if (data_out !== m_dout || lane_out !== m_lout) begin
          n_errors++;
          $display("FAIL mon_data_lane cyc=%0d got %h/%b want %h/%b", cyc, data_out, lane_out, m_dout, m_lout);
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset     = 1'b1;
    valid_in0 = 1'b1;
    data_in0  = 4'hF;
    for (int i = 0; i < 2; i++) begin
      tick();
      mon_en = 1'b1;
      n_checks++;
      if (ready_in0 !== 1'b0 || valid_out !== 1'b0 || data_out !== 4'h0) begin
        n_errors++;
        $display("FAIL reset_outputs got rdy0=%b v=%b d=%h want 0 0 0", ready_in0, valid_out, data_out);
      end
    end
    do_reset(0);
    ready_out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (valid_out !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_idle got valid_out=%b want 0", valid_out);
      end
    end
  endtask

  task automatic test_interleave();
    do_reset(1);
    ready_out = 1'b1;
    drive(1'b1, 4'h1, 1'b1, 4'h2);
    drive(1'b1, 4'h3, 1'b1, 4'h4);
    idle(6);
    exp_q = '{5'h01, 5'h12, 5'h03, 5'h14};
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL interleave_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i] || obs_cyc[i] != obs_cyc[0] + i) begin
        n_errors++;
        $display("FAIL interleave_word%0d got %h@%0d want %h@%0d", i, obs_q[i], obs_cyc[i], exp_q[i], obs_cyc[0] + i);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1);
    ready_out = 1'b0;
    drive(1'b1, 4'hA, 1'b1, 4'hB);
    drive(1'b1, 4'hC, 1'b1, 4'hD);
    drive(1'b1, 4'hE, 1'b1, 4'hF);
    n_checks++;
    if (ready_in0 !== 1'b0 || ready_in1 !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_full got rdy0=%b rdy1=%b want 0 0", ready_in0, ready_in1);
    end
    for (int i = 0; i < 3; i++) begin
      idle(1);
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== 4'hA || lane_out !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_hold got v=%b d=%h l=%b want 1 a 0", valid_out, data_out, lane_out);
      end
    end
    ready_out = 1'b1;
    idle(8);
    exp_q = '{5'h0A, 5'h1B, 5'h0C, 5'h1D, 5'h0E};
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL bp_word%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_strict_wait();
    do_reset(1);
    ready_out = 1'b1;
    drive(1'b1, 4'h5, 1'b0, 4'h0);
    drive(1'b1, 4'h6, 1'b0, 4'h0);
    idle(4);
`ifndef MUX2A1_SKIP_EMPTY_EN
    n_checks++;
    if (valid_out !== 1'b0 || obs_q.size() != 1) begin
      n_errors++;
      $display("FAIL strict_wait got v=%b sent=%0d want 0 1", valid_out, obs_q.size());
    end
`endif
    drive(1'b0, 4'h0, 1'b1, 4'h7);
    idle(4);
`ifdef MUX2A1_SKIP_EMPTY_EN
    exp_q = '{5'h05, 5'h06, 5'h17};
`else
    exp_q = '{5'h05, 5'h17, 5'h06};
`endif
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL wait_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL wait_word%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
`ifdef MUX2A1_SKIP_EMPTY_EN
    n_checks++;
    if (obs_q.size() < 2 || obs_cyc[1] != obs_cyc[0] + 1) begin
      n_errors++;
      $display("FAIL skip_b2b got sent=%0d want back-to-back 5,6", obs_q.size());
    end
`endif
  endtask

  task automatic test_mid_reset();
    do_reset(1);
    ready_out = 1'b0;
    drive(1'b1, 4'h1, 1'b1, 4'h2);
    drive(1'b1, 4'h3, 1'b0, 4'h0);
    reset = 1'b1;
    idle(1);
    n_checks++;
    if (valid_out !== 1'b0 || ready_in0 !== 1'b0 || ready_in1 !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_flush got v=%b rdy=%b%b want 0 00", valid_out, ready_in0, ready_in1);
    end
    do_reset(0);
    n_checks++;
    if (ready_in0 !== 1'b1 || ready_in1 !== 1'b1) begin
      n_errors++;
      $display("FAIL midrst_empty got rdy=%b%b want 11", ready_in0, ready_in1);
    end
    ready_out = 1'b1;
    drive(1'b0, 4'h0, 1'b1, 4'h9);
    idle(3);
`ifndef MUX2A1_SKIP_EMPTY_EN
    n_checks++;
    if (valid_out !== 1'b0 || obs_q.size() != 0) begin
      n_errors++;
      $display("FAIL midrst_wait got v=%b sent=%0d want 0 0", valid_out, obs_q.size());
    end
    exp_q = '{5'h08, 5'h19};
`else
    exp_q = '{5'h19, 5'h08};
`endif
    drive(1'b1, 4'h8, 1'b0, 4'h0);
    idle(4);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL midrst_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL midrst_word%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int lane_seen[2];
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      ready_out = ($urandom_range(0, 9) < 7);
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    ready_out = 1'b1;
    idle(10);
    lane_seen[0] = 0;
    lane_seen[1] = 0;
    foreach (obs_q[i]) lane_seen[obs_q[i][4]]++;
    n_checks++;
    if (m_q0.size() != 0 || m_q1.size() != 0 || valid_out !== 1'b0 || lane_seen[0] == 0 || lane_seen[1] == 0) begin
      n_errors++;
      $display("FAIL random_drain got v=%b l0=%0d l1=%0d want drained with both lanes", valid_out, lane_seen[0], lane_seen[1]);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_interleave();
    test_backpressure();
    test_strict_wait();
    test_mid_reset();
    test_random();
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
